// File: rtl/muldiv_engine_pkg.sv
// Shared CPU package slice for the multiply/divide engine.
//   oper_t          decoded execute-stage operation
//   muldiv_state_t  engine sequencing states
//   muldiv_resp_t   {ready, hilo} response bundle
//   DIV_ITERS       radix-2 divide iterations (one quotient bit each)
// Helper functions classify operations for acceptance and datapath control.
package muldiv_engine_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_MADD  = 4'd3,
        OP_MADDU = 4'd4,
        OP_MSUB  = 4'd5,
        OP_MSUBU = 4'd6,
        OP_DIV   = 4'd7,
        OP_DIVU  = 4'd8,
        OP_MTHI  = 4'd9,
        OP_MTLO  = 4'd10
    } oper_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        ACC  = 3'd2,
        DIV  = 3'd3,
        FIX  = 3'd4,
        DONE = 3'd5
    } muldiv_state_t;

    localparam int DIV_ITERS = 32;
    localparam int DIV_CNT_W = $clog2(DIV_ITERS);

    typedef struct packed {
        logic        ready;
        logic [63:0] hilo;
    } muldiv_resp_t;

    // Operations that occupy the engine for more than the accept cycle.
    function automatic logic op_uses_engine(input oper_t op);
        return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU,
                          OP_MSUB, OP_MSUBU, OP_DIV, OP_DIVU};
    endfunction

    function automatic logic op_is_signed(input oper_t op);
        return op inside {OP_MULT, OP_MADD, OP_MSUB, OP_DIV};
    endfunction

    function automatic logic op_is_div(input oper_t op);
        return op inside {OP_DIV, OP_DIVU};
    endfunction

    function automatic logic op_is_acc(input oper_t op);
        return op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    endfunction

    function automatic logic op_is_sub(input oper_t op);
        return op inside {OP_MSUB, OP_MSUBU};
    endfunction

endpackage

// File: rtl/div_radix2.sv
// Radix-2 restoring divider on unsigned 32-bit magnitudes.
//   clk, rst        clock, synchronous active-high reset
//   abort           drop an in-flight division
//   start           load dividend/divisor magnitudes (one-cycle pulse)
//   dividend        dividend magnitude
//   divisor         divisor magnitude
//   done            high during the final iteration cycle
//   quotient        quotient register (final the cycle after done)
//   remainder       partial/final remainder register
// A zero divisor makes every trial subtraction succeed, so the quotient
// becomes all ones and the remainder collects the dividend bits.
module div_radix2
    import muldiv_engine_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        abort,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0]          rem_q, rem_d;
    logic [31:0]          quo_q, quo_d;
    logic [31:0]          dvs_q, dvs_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic                 busy_q, busy_d;

    logic [32:0] shifted;
    logic [33:0] trial;

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;

        // The dividend sits in the quotient register and shifts out MSB first
        // while quotient bits shift in at the bottom.
        shifted = {rem_q, quo_q[31]};
        trial   = {1'b0, shifted} - {2'b00, dvs_q};

        if (start) begin
            rem_d  = '0;
            quo_d  = dividend;
            dvs_d  = divisor;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (!trial[33]) begin
                rem_d = trial[31:0];
                quo_d = {quo_q[30:0], 1'b1};
            end else begin
                rem_d = shifted[31:0];
                quo_d = {quo_q[30:0], 1'b0};
            end
            cnt_d = cnt_q + DIV_CNT_W'(1);
            if (cnt_q == DIV_CNT_W'(DIV_ITERS - 1)) begin
                busy_d = 1'b0;
            end
        end

        if (abort) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign done      = busy_q && (cnt_q == DIV_CNT_W'(DIV_ITERS - 1));
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/muldiv_engine.sv
// Multi-cycle multiply/divide engine for the execute stage.
//   clk, rst            clock, synchronous active-high reset
//   flush               exception flush, cancels any in-flight operation
//   req_valid/req_op    execute-stage instruction and its decoded op
//   req_is_multicyc     decoder flag: op uses this engine
//   req_reg0/req_reg1   rs / rt operands
//   req_hilo            current {HI, LO}
//   ack                 downstream accepts the finished instruction
//   resp_ready          execute stage may advance
//   resp_hilo           new {HI, LO}
// MTHI/MTLO and non-engine ops are answered combinationally from IDLE.
module muldiv_engine
    import muldiv_engine_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req_valid,
    input  oper_t       req_op,
    input  logic        req_is_multicyc,
    input  logic [31:0] req_reg0,
    input  logic [31:0] req_reg1,
    input  logic [63:0] req_hilo,
    input  logic        ack,
    output logic        resp_ready,
    output logic [63:0] resp_hilo
);

    muldiv_state_t state_q, state_d;
    oper_t         op_q, op_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   b_q, b_d;
    logic [63:0]   hilo_q, hilo_d;
    logic [63:0]   result_q, result_d;
    logic          blk_q, blk_d;

    logic          accept;
    logic          req_signed;
    logic          div_start;
    logic [31:0]   div_dividend, div_divisor;
    logic          div_done;
    logic [31:0]   div_quo, div_rem;

    logic signed [32:0] mul_a33, mul_b33;
    logic signed [63:0] mul_a64, mul_b64, product;
    logic               neg_q, neg_r;
    muldiv_resp_t       resp;

    // blk_q suppresses re-accepting the instruction that was just acked,
    // since the execute stage still presents it for one more cycle.
    assign accept = (state_q == IDLE) && !blk_q && !rst && !flush &&
                    req_valid && req_is_multicyc && op_uses_engine(req_op);

    // Divider magnitudes come straight from the request so that the first
    // iteration runs in the cycle after acceptance.
    assign req_signed   = op_is_signed(req_op);
    assign div_dividend = (req_signed && req_reg0[31]) ? -req_reg0 : req_reg0;
    assign div_divisor  = (req_signed && req_reg1[31]) ? -req_reg1 : req_reg1;
    assign div_start    = accept && op_is_div(req_op);

    div_radix2 u_div (
        .clk       (clk),
        .rst       (rst),
        .abort     (flush),
        .start     (div_start),
        .dividend  (div_dividend),
        .divisor   (div_divisor),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // 33x33 signed multiply; only the low 64 product bits matter, so the
    // operands are widened to 64 and the product is kept modulo 2^64.
    always_comb begin
        mul_a33 = {op_is_signed(op_q) & a_q[31], a_q};
        mul_b33 = {op_is_signed(op_q) & b_q[31], b_q};
        mul_a64 = {{31{mul_a33[32]}}, mul_a33};
        mul_b64 = {{31{mul_b33[32]}}, mul_b33};
        product = mul_a64 * mul_b64;
    end

    assign neg_q = op_is_signed(op_q) && (a_q[31] ^ b_q[31]);
    assign neg_r = op_is_signed(op_q) && a_q[31];

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        hilo_d   = hilo_q;
        result_d = result_q;
        blk_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = req_op;
                    a_d     = req_reg0;
                    b_d     = req_reg1;
                    hilo_d  = req_hilo;
                    state_d = op_is_div(req_op) ? DIV : MUL;
                end
            end
            MUL: begin
                result_d = product;
                state_d  = op_is_acc(op_q) ? ACC : DONE;
            end
            ACC: begin
                result_d = op_is_sub(op_q) ? (hilo_q - result_q) : (hilo_q + result_q);
                state_d  = DONE;
            end
            DIV: begin
                if (div_done) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // Divide-by-zero returns the raw dividend, not the magnitude.
                if (b_q == 32'd0) begin
                    result_d = {a_q, 32'hFFFF_FFFF};
                end else begin
                    result_d = {neg_r ? -div_rem : div_rem,
                                neg_q ? -div_quo : div_quo};
                end
                state_d = DONE;
            end
            DONE: begin
                if (ack) begin
                    state_d = IDLE;
                    blk_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d  = IDLE;
            result_d = '0;
            blk_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_NOP;
            a_q      <= '0;
            b_q      <= '0;
            hilo_q   <= '0;
            result_q <= '0;
            blk_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hilo_q   <= hilo_d;
            result_q <= result_d;
            blk_q    <= blk_d;
        end
    end

    // While reset is held the engine looks idle regardless of the state
    // register, so the stage sees a clean pass-through.
    always_comb begin
        resp.ready = 1'b0;
        resp.hilo  = req_hilo;
        if (rst || (state_q == IDLE)) begin
            resp.ready = !accept;
            if (req_valid && (req_op == OP_MTHI)) begin
                resp.hilo = {req_reg0, req_hilo[31:0]};
            end else if (req_valid && (req_op == OP_MTLO)) begin
                resp.hilo = {req_hilo[63:32], req_reg0};
            end
        end else if (state_q == DONE) begin
            resp.ready = 1'b1;
            resp.hilo  = result_q;
        end
    end

    assign resp_ready = resp.ready;
    assign resp_hilo  = resp.hilo;

endmodule

// File: tb/tb_muldiv_engine.sv
// Directed bench for muldiv_engine: a vector table of engine operations with
// hand-computed results and latencies, plus sequences for reset, flush and
// combinational pass-through behaviour.
module tb_muldiv_engine;
    import muldiv_engine_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        req_valid;
    oper_t       req_op;
    logic        req_is_multicyc;
    logic [31:0] req_reg0;
    logic [31:0] req_reg1;
    logic [63:0] req_hilo;
    logic        ack;
    logic        resp_ready;
    logic [63:0] resp_hilo;

    int n_cmp;
    int n_bad;

    typedef struct {
        string       name;
        oper_t       op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] hilo;
        logic [63:0] exp;
        int          lat;
        int          hold;
    } vec_t;

    vec_t vecs[14];

    muldiv_engine dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .req_valid       (req_valid),
        .req_op          (req_op),
        .req_is_multicyc (req_is_multicyc),
        .req_reg0        (req_reg0),
        .req_reg1        (req_reg1),
        .req_hilo        (req_hilo),
        .ack             (ack),
        .resp_ready      (resp_ready),
        .resp_hilo       (resp_hilo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Apply one engine op at a negedge (accept cycle T), scramble the request
    // while busy, expect resp_ready exactly at T+lat, optionally hold ack low,
    // then ack and confirm the still-presented instruction is not re-accepted.
    task automatic run_op(input vec_t v);
        @(negedge clk);
        req_valid = 1'b1; req_is_multicyc = 1'b1; req_op = v.op;
        req_reg0 = v.a; req_reg1 = v.b; req_hilo = v.hilo; ack = 1'b0;
        #1 check({v.name, "_accept_ready"}, {63'd0, resp_ready}, 64'd0);
        @(posedge clk);
        for (int k = 1; k <= v.lat; k++) begin
            @(negedge clk);
            if (k < v.lat) begin
                req_op    = OP_MTHI;
                req_valid = k[0];
                req_reg0  = ~v.a;
                req_reg1  = v.a ^ 32'h5A5A_5A5A;
                req_hilo  = ~v.hilo;
                #1 check({v.name, "_busy_ready"}, {63'd0, resp_ready}, 64'd0);
            end else begin
                req_valid = 1'b1; req_op = v.op;
                req_reg0 = v.a; req_reg1 = v.b; req_hilo = v.hilo;
                #1 check({v.name, "_done_ready"}, {63'd0, resp_ready}, 64'd1);
                check({v.name, "_result"}, resp_hilo, v.exp);
            end
        end
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            #1 check({v.name, "_hold_ready"}, {63'd0, resp_ready}, 64'd1);
            check({v.name, "_hold_result"}, resp_hilo, v.exp);
        end
        $display("op %s a=%h b=%h hilo=%h -> %h (expected %h)",
                 v.name, v.a, v.b, v.hilo, resp_hilo, v.exp);
        ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ack = 1'b0;
        #1 check({v.name, "_blocked_ready"}, {63'd0, resp_ready}, 64'd1);
        check({v.name, "_blocked_hilo"}, resp_hilo, v.hilo);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        #1 check({v.name, "_no_reaccept"}, {63'd0, resp_ready}, 64'd1);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        vecs[0]  = '{"MULT_m1x2",    OP_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 64'h0,                    64'hFFFF_FFFF_FFFF_FFFE, 2, 0};
        vecs[1]  = '{"MULTU_ffx2",   OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0,                    64'h0000_0001_FFFF_FFFE, 2, 0};
        vecs[2]  = '{"MULT_minsq",   OP_MULT,  32'h8000_0000, 32'h8000_0000, 64'h0,                    64'h4000_0000_0000_0000, 2, 0};
        vecs[3]  = '{"MADDU_carry",  OP_MADDU, 32'h0000_0001, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF, 64'h0000_0001_0000_0000, 3, 0};
        vecs[4]  = '{"MSUB_3x4",     OP_MSUB,  32'h0000_0003, 32'h0000_0004, 64'h0,                    64'hFFFF_FFFF_FFFF_FFF4, 3, 0};
        vecs[5]  = '{"MADD_neg",     OP_MADD,  32'hFFFF_FFFE, 32'h0000_0003, 64'h0000_0000_0000_000A, 64'h0000_0000_0000_0004, 3, 0};
        vecs[6]  = '{"MSUBU_borrow", OP_MSUBU, 32'hFFFF_FFFF, 32'h0000_0001, 64'h0000_0001_0000_0000, 64'h0000_0000_0000_0001, 3, 0};
        vecs[7]  = '{"DIV_m7d2",     OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 64'h0,                    64'hFFFF_FFFF_FFFF_FFFD, 34, 3};
        vecs[8]  = '{"DIVU_by0",     OP_DIVU,  32'h1234_5678, 32'h0000_0000, 64'h0,                    64'h1234_5678_FFFF_FFFF, 34, 0};
        vecs[9]  = '{"DIV_wrap",     OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0,                    64'h0000_0000_8000_0000, 34, 0};
        vecs[10] = '{"DIV_negby0",   OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 64'h0,                    64'hFFFF_FFF9_FFFF_FFFF, 34, 0};
        vecs[11] = '{"DIVU_100d7",   OP_DIVU,  32'd100,       32'd7,         64'h0,                    64'h0000_0002_0000_000E, 34, 0};
        vecs[12] = '{"DIV_100dm7",   OP_DIV,   32'd100,       32'hFFFF_FFF9, 64'h0,                    64'h0000_0002_FFFF_FFF2, 34, 0};
        vecs[13] = '{"MULT_5x6",     OP_MULT,  32'd5,         32'd6,         64'h0,                    64'h0000_0000_0000_001E, 2, 0};

        // Reset: outputs pass through while and after reset is held.
        rst = 1'b1; flush = 1'b0; ack = 1'b0;
        req_valid = 1'b0; req_is_multicyc = 1'b0; req_op = OP_NOP;
        req_reg0 = '0; req_reg1 = '0; req_hilo = 64'h0123_4567_89AB_CDEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 check("reset_ready", {63'd0, resp_ready}, 64'd1);
        check("reset_hilo", resp_hilo, 64'h0123_4567_89AB_CDEF);
        rst = 1'b0;
        @(negedge clk);
        #1 check("post_reset_ready", {63'd0, resp_ready}, 64'd1);
        check("post_reset_hilo", resp_hilo, 64'h0123_4567_89AB_CDEF);

        // Combinational MTHI and a non-engine op.
        req_valid = 1'b1; req_op = OP_MTHI; req_reg0 = 32'hDEAD_BEEF;
        req_hilo = 64'h1111_1111_2222_2222;
        #1 check("mthi_hilo", resp_hilo, 64'hDEAD_BEEF_2222_2222);
        check("mthi_ready", {63'd0, resp_ready}, 64'd1);
        req_op = OP_MULT; req_is_multicyc = 1'b0;
        #1 check("nomulticyc_ready", {63'd0, resp_ready}, 64'd1);
        check("nomulticyc_hilo", resp_hilo, 64'h1111_1111_2222_2222);

        // Flush blocks acceptance in the same cycle.
        req_is_multicyc = 1'b1; flush = 1'b1;
        #1 check("flush_vs_accept", {63'd0, resp_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        #1 check("flush_no_accept", {63'd0, resp_ready}, 64'd1);

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i]);
        end

        // DIV flushed at T+10 -> idle and ready at T+11.
        @(negedge clk);
        req_valid = 1'b1; req_is_multicyc = 1'b1; req_op = OP_DIV;
        req_reg0 = 32'd100; req_reg1 = 32'd7; req_hilo = 64'h0000_0003_0000_0004;
        #1 check("flushdiv_accept", {63'd0, resp_ready}, 64'd0);
        @(posedge clk);
        for (int k = 1; k < 10; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        @(negedge clk);
        flush = 1'b1;
        #1 check("flushdiv_busy_T10", {63'd0, resp_ready}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        #1 check("flushdiv_ready_T11", {63'd0, resp_ready}, 64'd1);
        check("flushdiv_hilo_T11", resp_hilo, 64'h0000_0003_0000_0004);
        $display("flush of DIV at T+10 -> ready=%0d", resp_ready);
        run_op(vecs[13]);

        // Reset at T+5 of a DIV, then a same-cycle MTLO.
        @(negedge clk);
        req_valid = 1'b1; req_is_multicyc = 1'b1; req_op = OP_DIV;
        req_reg0 = 32'hFFFF_FFF9; req_reg1 = 32'd2; req_hilo = 64'h0;
        #1 check("rstdiv_accept", {63'd0, resp_ready}, 64'd0);
        @(posedge clk);
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1; req_hilo = 64'h5555_6666_7777_8888;
        #1 check("rstdiv_during_ready", {63'd0, resp_ready}, 64'd1);
        check("rstdiv_during_hilo", resp_hilo, 64'h5555_6666_7777_8888);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b1; req_is_multicyc = 1'b0; req_op = OP_MTLO;
        req_reg0 = 32'hA5A5_A5A5; req_hilo = 64'h1111_1111_2222_2222;
        #1 check("mtlo_ready", {63'd0, resp_ready}, 64'd1);
        check("mtlo_hilo", resp_hilo, 64'h1111_1111_A5A5_A5A5);
        $display("reset mid-DIV then MTLO -> ready=%0d hilo=%h", resp_ready, resp_hilo);
        @(negedge clk);
        req_valid = 1'b0;
        run_op(vecs[11]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
